lap_scheduler: RTL and testbench

LAP_SCHEDULER -- requirements
Module: lap_scheduler

---
 rtl/lap_scheduler_if.sv | 30 +++
 rtl/lap_scheduler.sv | 178 +++++++++++++++++
 tb/tb_lap_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lap_scheduler_if.sv
// Button inputs and scheduler outputs of the lap scheduler, bundled as one port.
interface lap_scheduler_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          st_n;
  logic          lap_n;
  logic          rev_n;
  logic          timer_en;
  logic          timer_rst;
  logic          lap_wr_en;
  logic [AW-1:0] lap_wr_addr;
  logic [AW-1:0] lap_rd_addr;
  logic [AW:0]   lap_count;
  logic          full;
  logic          review_mode;

  modport master (
    output st_n, lap_n, rev_n,
    input  timer_en, timer_rst, lap_wr_en, lap_wr_addr, lap_rd_addr,
           lap_count, full, review_mode
  );

  modport slave (
    input  st_n, lap_n, rev_n,
    output timer_en, timer_rst, lap_wr_en, lap_wr_addr, lap_rd_addr,
           lap_count, full, review_mode
  );
endinterface

// File: rtl/lap_scheduler.sv
// Stopwatch control: debounced buttons drive a run/stop/review FSM that paces the
// timer and writes lap snapshots into a small lap memory.
module lap_scheduler #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 10,
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter int unsigned DEPTH      = 8
) (
  input  logic            clk,
  input  logic            reset,
  lap_scheduler_if.slave  bus
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned RATIO     = CLK_HZ / TICK_HZ;
  localparam int unsigned PW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int unsigned NBTN      = 3;

  typedef enum logic [1:0] {
    CLEARED = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2,
    REVIEW  = 2'd3
  } state_t;

  // Button index order: 0 = st, 1 = lap, 2 = rev
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] deb_q;
  logic [DW-1:0]   deb_cnt_q [NBTN];
  logic [NBTN-1:0] press_c;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            timer_en_q, timer_en_d;
  logic            timer_rst_q, timer_rst_d;
  logic            lap_wr_en_q, lap_wr_en_d;
  logic            full_q, full_d;
  logic            review_q, review_d;
  logic            st_ev, lap_ev, rev_ev;
  logic [CW-1:0]   rd_inc;

  // Synchronizers and debouncers; released (1) is the idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      for (int i = 0; i < NBTN; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {bus.rev_n, bus.lap_n, bus.st_n};
      sync2_q <= sync1_q;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // A press is the cycle in which the debounced level is about to accept 1->0
  always_comb begin
    press_c = '0;
    for (int i = 0; i < NBTN; i++) begin
      press_c[i] = deb_q[i] & ~sync2_q[i] & (deb_cnt_q[i] == DW'(DEB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEARED;
      presc_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      count_q     <= '0;
      timer_en_q  <= 1'b0;
      timer_rst_q <= 1'b0;
      lap_wr_en_q <= 1'b0;
      full_q      <= 1'b0;
      review_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      count_q     <= count_d;
      timer_en_q  <= timer_en_d;
      timer_rst_q <= timer_rst_d;
      lap_wr_en_q <= lap_wr_en_d;
      full_q      <= full_d;
      review_q    <= review_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    count_d     = count_q;
    timer_en_d  = 1'b0;
    timer_rst_d = 1'b0;
    lap_wr_en_d = 1'b0;

    st_ev  = press_c[0];
    lap_ev = press_c[1] & ~press_c[0];
    rev_ev = press_c[2] & ~press_c[1] & ~press_c[0];
    rd_inc = CW'(rd_addr_q) + CW'(1);

    // Address/count advance the cycle after the write strobe; address parks at the last slot
    if (lap_wr_en_q) begin
      count_d = count_q + CW'(1);
      if (wr_addr_q != AW'(DEPTH - 1)) wr_addr_d = wr_addr_q + AW'(1);
    end

    case (state_q)
      CLEARED: begin
        if (st_ev) state_d = RUNNING;
      end
      RUNNING: begin
        if (presc_q == PW'(RATIO - 1)) begin
          presc_d    = '0;
          timer_en_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (st_ev)                  state_d     = STOPPED;
        else if (lap_ev && !full_q) lap_wr_en_d = 1'b1;
      end
      STOPPED: begin
        if (st_ev) begin
          state_d = RUNNING;
        end else if (lap_ev) begin
          state_d     = CLEARED;
          timer_rst_d = 1'b1;
          count_d     = '0;
          wr_addr_d   = '0;
          rd_addr_d   = '0;
          presc_d     = '0;
        end else if (rev_ev && count_q != '0) begin
          state_d   = REVIEW;
          rd_addr_d = '0;
        end
      end
      REVIEW: begin
        if (st_ev || rev_ev) begin
          state_d = STOPPED;
        end else if (lap_ev) begin
          rd_addr_d = (rd_inc >= count_q) ? '0 : rd_addr_q + AW'(1);
        end
      end
      default: state_d = CLEARED;
    endcase

    full_d   = (count_d == CW'(DEPTH));
    review_d = (state_d == REVIEW);
  end

  assign bus.timer_en    = timer_en_q;
  assign bus.timer_rst   = timer_rst_q;
  assign bus.lap_wr_en   = lap_wr_en_q;
  assign bus.lap_wr_addr = wr_addr_q;
  assign bus.lap_rd_addr = rd_addr_q;
  assign bus.lap_count   = count_q;
  assign bus.full        = full_q;
  assign bus.review_mode = review_q;

endmodule

// File: tb/tb_lap_scheduler.sv
// Directed bench for lap_scheduler with small clock/debounce/depth parameters.
module tb_lap_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   en_cnt  = 0;
  int   rst_cnt = 0;
  int   wr_cnt  = 0;
  int   wide    = 0;
  int   pt [64];
  logic [1:0] wr_log [64];
  logic prev_en = 1'b0, prev_rst = 1'b0, prev_wr = 1'b0;
  int   base, e0, w0;

  lap_scheduler_if #(.DEPTH(4)) bus ();

  lap_scheduler #(
    .CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(2), .DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Pulse logging and single-cycle width monitoring
  always @(negedge clk) begin
    if (bus.timer_en) begin
      if (en_cnt < 64) pt[en_cnt] = cyc;
      en_cnt = en_cnt + 1;
    end
    if (bus.timer_rst) rst_cnt = rst_cnt + 1;
    if (bus.lap_wr_en) begin
      if (wr_cnt < 64) wr_log[wr_cnt] = bus.lap_wr_addr;
      wr_cnt = wr_cnt + 1;
    end
    if ((bus.timer_en && prev_en) || (bus.timer_rst && prev_rst) || (bus.lap_wr_en && prev_wr))
      wide = wide + 1;
    prev_en  = bus.timer_en;
    prev_rst = bus.timer_rst;
    prev_wr  = bus.lap_wr_en;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic s, input logic l, input logic r, input int low_cyc);
    @(posedge clk); #1;
    bus.st_n = ~s; bus.lap_n = ~l; bus.rev_n = ~r;
    repeat (low_cyc) @(posedge clk);
    #1;
    bus.st_n = 1'b1; bus.lap_n = 1'b1; bus.rev_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_timer_en"},    int'(bus.timer_en),    0);
    chk({pfx, "_timer_rst"},   int'(bus.timer_rst),   0);
    chk({pfx, "_lap_wr_en"},   int'(bus.lap_wr_en),   0);
    chk({pfx, "_wr_addr"},     int'(bus.lap_wr_addr), 0);
    chk({pfx, "_rd_addr"},     int'(bus.lap_rd_addr), 0);
    chk({pfx, "_lap_count"},   int'(bus.lap_count),   0);
    chk({pfx, "_full"},        int'(bus.full),        0);
    chk({pfx, "_review_mode"}, int'(bus.review_mode), 0);
  endtask

  initial begin
    bus.st_n = 1'b1; bus.lap_n = 1'b1; bus.rev_n = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");

    // One-cycle glitch is rejected; a held press starts the timer once
    press(1'b1, 1'b0, 1'b0, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("glitch_no_event", en_cnt, 0);
    press(1'b1, 1'b0, 1'b0, 5);
    repeat (20) @(posedge clk);
    #1;
    chk("held_one_event", int'(en_cnt > 0), 1);

    // Run for 35 cycles: exactly three ticks, ten cycles apart, none after stop
    do_reset();
    base = en_cnt;
    @(posedge clk); #1;
    bus.st_n = 1'b0;
    repeat (5) @(posedge clk);
    #1; bus.st_n = 1'b1;
    repeat (30) @(posedge clk);
    #1; bus.st_n = 1'b0;
    repeat (5) @(posedge clk);
    #1; bus.st_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("ticks_in_35", en_cnt - base, 3);
    chk("tick_period", pt[base + 1] - pt[base], 10);

    // Clear from STOPPED, rev ignored in CLEARED, then fill the lap memory
    press(1'b0, 1'b1, 1'b0, 5);
    chk("clear_rst_pulses", rst_cnt, 1);
    chk("clear_count", int'(bus.lap_count), 0);
    press(1'b0, 1'b0, 1'b1, 5);
    chk("cleared_rev_ignored", int'(bus.review_mode), 0);
    press(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, 5);
    chk("fill_strobes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_addr%0d", i), int'(wr_log[i]), i);
    chk("fill_count", int'(bus.lap_count), 4);
    chk("fill_full", int'(bus.full), 1);

    // Stop, clear, run again with three laps; st+lap together stops without a write
    press(1'b1, 1'b0, 1'b0, 5);
    press(1'b0, 1'b1, 1'b0, 5);
    chk("clear2_rst_pulses", rst_cnt, 2);
    press(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 5);
    chk("three_laps_count", int'(bus.lap_count), 3);
    chk("three_laps_not_full", int'(bus.full), 0);
    w0 = wr_cnt;
    press(1'b1, 1'b1, 1'b0, 5);
    chk("prio_no_write", wr_cnt - w0, 0);
    chk("prio_count", int'(bus.lap_count), 3);
    e0 = en_cnt;
    repeat (25) @(posedge clk);
    #1;
    chk("prio_stopped", en_cnt - e0, 0);

    // Review cycles through 3 laps and wraps; exit holds the read address
    press(1'b0, 1'b0, 1'b1, 5);
    chk("review_enter", int'(bus.review_mode), 1);
    chk("review_rd0", int'(bus.lap_rd_addr), 0);
    press(1'b0, 1'b1, 1'b0, 5);
    chk("review_rd1", int'(bus.lap_rd_addr), 1);
    press(1'b0, 1'b1, 1'b0, 5);
    chk("review_rd2", int'(bus.lap_rd_addr), 2);
    press(1'b0, 1'b1, 1'b0, 5);
    chk("review_rd_wrap", int'(bus.lap_rd_addr), 0);
    press(1'b0, 1'b0, 1'b1, 5);
    chk("review_exit_rev", int'(bus.review_mode), 0);
    press(1'b0, 1'b0, 1'b1, 5);
    press(1'b0, 1'b1, 1'b0, 5);
    chk("review2_rd1", int'(bus.lap_rd_addr), 1);
    press(1'b1, 1'b0, 1'b0, 5);
    chk("review_exit_st", int'(bus.review_mode), 0);
    chk("review_rd_held", int'(bus.lap_rd_addr), 1);

    // Clear from STOPPED empties everything; rev then has nothing to review
    press(1'b0, 1'b1, 1'b0, 5);
    chk("clear3_rst_pulses", rst_cnt, 3);
    chk("clear3_count", int'(bus.lap_count), 0);
    chk("clear3_wr_addr", int'(bus.lap_wr_addr), 0);
    chk("clear3_rd_addr", int'(bus.lap_rd_addr), 0);
    press(1'b0, 1'b0, 1'b1, 5);
    chk("clear3_rev_ignored", int'(bus.review_mode), 0);

    // Reset mid-run zeroes every output and leaves the timer idle
    press(1'b1, 1'b0, 1'b0, 5);
    press(1'b0, 1'b1, 1'b0, 5);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midrun_reset");
    reset = 1'b0;
    e0 = en_cnt;
    repeat (25) @(posedge clk);
    #1;
    chk("post_reset_idle", en_cnt - e0, 0);

    chk("pulse_width", wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
